hidden_instr_feeder: RTL and testbench
======================================

# hidden_instr_feeder

Program buffer and instruction sequencer that sits directly upstream of the HiddenCPU core and supplies its 8-bit instruction byte (opcode[7:6], src/dst addresses[5:2]). The host loads a short program byte-by-byte, then the feeder replays it to the core with a valid/ready handshake. It wraps at end of program and accepts branch redirects from the core. Replaces hand-driving io_in with per-cycle instructions during bring-up.

## Interface
- DEPTH, 16, program buffer entries (power of two)
- AW, 4, log2(DEPTH)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- cmd_load  in  1  pulse: enter LOAD, clear program
- cmd_run  in  1  pulse: start or resume RUN
- halt  in  1  pulse: stop issuing instructions
- load_valid  in  1  host byte valid (LOAD only)
- load_data  in  8  host instruction byte
- load_ready  out  1  buffer can accept a byte
- load_done  in  1  pulse: end LOAD, return to IDLE
- instr_out  out  8  instruction to core
- instr_valid  out  1  instr_out valid
- instr_ready  in  1  core accepts instr_out this cycle
- redirect_valid  in  1  core branch taken (qualifies with accept)
- redirect_offset  in  8  branch offset (core's r3)
- prog_len  out  AW+1  number of loaded bytes, 0..DEPTH
- fetch_ptr  out  AW  index of current instruction
- instr_count  out  8  accepted-instruction counter
- wrapped  out  1  one-cycle pulse on end-of-program wrap
- state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3

## Operation
- Accept = instr_valid & instr_ready.
- IDLE: cmd_load -> LOAD, prog_len<=0. cmd_run with prog_len>0 -> RUN, fetch_ptr<=0, instr_count<=0. cmd_run with prog_len==0 ignored. cmd_load and cmd_run together: load wins.
- LOAD: load_ready = (prog_len<DEPTH). On load_valid & load_ready: mem[prog_len]<=load_data, prog_len++. load_valid with load_ready=0: byte dropped, no state change. load_done -> IDLE; a byte presented in the same cycle as load_done is still written.
- RUN: instr_valid=1, instr_out=mem[fetch_ptr] (combinational read). On accept, instr_count++ (wraps 255->0) and the next fetch_ptr is:
  - redirect_valid=1: t=(fetch_ptr+redirect_offset[AW-1:0]) mod DEPTH; fetch_ptr<=(t<prog_len)?t:0. No wrapped pulse.
  - else if fetch_ptr==prog_len-1: fetch_ptr<=0, wrapped pulses next cycle.
  - else fetch_ptr++.
- redirect_valid without accept: ignored.
- halt in RUN -> HALT. A same-cycle accept completes: pointer and count update, then HALT.
- HALT: instr_valid=0. cmd_run -> RUN at unchanged fetch_ptr and instr_count. cmd_load -> LOAD (prog_len<=0). Both: load wins.
- instr_out=8'h00 whenever state!=RUN.
- cmd_load in RUN ignored (halt first). load_valid outside LOAD ignored.

## Timing
- Reset (async): state=IDLE, prog_len=0, fetch_ptr=0, instr_count=0, wrapped=0, load_ready=0, instr_valid=0, instr_out=8'h00. Buffer contents not reset.
- All state transitions register on the clk edge following the command. instr_valid rises the cycle after cmd_run is sampled.
- A written byte is readable the cycle after its write.
- Zero-latency issue: back-to-back accepts deliver one instruction per cycle.
- A redirect target is on instr_out the cycle after the accept.
- rst mid-LOAD or mid-RUN aborts immediately. The program must be reloaded to be considered valid (prog_len=0).

## Test plan
- Reset, load 0x11,0x22,0x33, load_done, cmd_run, instr_ready=1 -> instr_out 0x11,0x22,0x33,0x11,… Wrapped pulses once per pass; instr_count=6 after 6 accepts.
- Load 17 bytes into DEPTH=16 -> load_ready falls after the 16th byte, 17th dropped, prog_len=16.
- Program of 8 bytes, redirect_valid with offset 3 on accept at ptr 2 -> next instr is mem[5]. Offset 7 at ptr 4 (t=11≥8) -> mem[0].
- instr_ready toggled 1,0,0,1 -> fetch_ptr advances only on accept cycles; instr_out held stable while stalled.
- halt concurrent with accept at ptr 1 -> HALT, fetch_ptr=2, instr_valid=0. cmd_run -> resumes with mem[2].
- cmd_run with prog_len=0 -> stays IDLE. Async rst asserted mid-RUN between edges -> outputs at reset values without a clock edge.

Source files
------------

// File: rtl/hidden_instr_feeder.sv
// rtl/hidden_instr_feeder.sv - program buffer and instruction sequencer feeding the HiddenCPU core
module hidden_instr_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_load,
  input  logic          cmd_run,
  input  logic          halt,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          load_done,
  output logic [7:0]    instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect_valid,
  input  logic [7:0]    redirect_offset,
  output logic [AW:0]   prog_len,
  output logic [AW-1:0] fetch_ptr,
  output logic [7:0]    instr_count,
  output logic          wrapped,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {sIdle = 2'd0, sLoad = 2'd1, sRun = 2'd2, sHalt = 2'd3} state_t;

  localparam logic [AW:0] DepthVal = (AW+1)'(DEPTH);
  localparam logic [AW:0] One      = (AW+1)'(1);

  state_t        curState, nextState;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   progLen;
  logic [AW-1:0] fetchPtr;
  logic [AW-1:0] redirTarget;
  logic [AW-1:0] nextPtr;
  logic [7:0]    instrCount;
  logic          wrappedQ;
  logic          accept;
  logic          wrEn;
  logic          lastEntry;
  logic          startRun;
  logic          clearProg;
  logic          unusedOffsetBits;

  assign unusedOffsetBits = ^redirect_offset[7:AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) curState <= sIdle;
    else     curState <= nextState;
  end

  always_comb begin
    nextState = curState;
    case (curState)
      sIdle:   if (cmd_load) nextState = sLoad;
               else if (cmd_run && progLen != '0) nextState = sRun;
      sLoad:   if (load_done) nextState = sIdle;
      sRun:    if (halt) nextState = sHalt;
      sHalt:   if (cmd_load) nextState = sLoad;
               else if (cmd_run) nextState = sRun;
      default: nextState = sIdle;
    endcase
  end

  always_comb begin
    load_ready  = 1'b0;
    instr_valid = 1'b0;
    instr_out   = 8'h00;
    case (curState)
      sLoad: load_ready = (progLen < DepthVal);
      sRun: begin
        instr_valid = 1'b1;
        instr_out   = mem[fetchPtr];
      end
      default: ;
    endcase
  end

  assign accept    = instr_valid & instr_ready;
  assign wrEn      = load_valid & load_ready;
  assign clearProg = cmd_load & ((curState == sIdle) | (curState == sHalt));
  assign startRun  = (curState == sIdle) & ~cmd_load & cmd_run & (progLen != '0);

  // Redirect targets beyond the loaded program fall back to the first entry.
  assign redirTarget = fetchPtr + redirect_offset[AW-1:0];
  assign lastEntry   = ({1'b0, fetchPtr} == (progLen - One));

  always_comb begin
    nextPtr = fetchPtr + 1'b1;
    if (redirect_valid) nextPtr = ({1'b0, redirTarget} < progLen) ? redirTarget : '0;
    else if (lastEntry) nextPtr = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      progLen    <= '0;
      fetchPtr   <= '0;
      instrCount <= 8'h00;
      wrappedQ   <= 1'b0;
    end else begin
      wrappedQ <= 1'b0;
      if (clearProg)  progLen <= '0;
      else if (wrEn)  progLen <= progLen + One;
      if (startRun) begin
        fetchPtr   <= '0;
        instrCount <= 8'h00;
      end else if (accept) begin
        fetchPtr   <= nextPtr;
        instrCount <= instrCount + 8'd1;
        wrappedQ   <= ~redirect_valid & lastEntry;
      end
    end
  end

  // Buffer contents survive reset; prog_len alone marks what is valid.
  always_ff @(posedge clk) begin
    if (wrEn) mem[progLen[AW-1:0]] <= load_data;
  end

  assign prog_len    = progLen;
  assign fetch_ptr   = fetchPtr;
  assign instr_count = instrCount;
  assign wrapped     = wrappedQ;
  assign state       = curState;

endmodule

// File: tb/tb_hidden_instr_feeder.sv
// tb/tb_hidden_instr_feeder.sv - self-checking bench for hidden_instr_feeder
module tb_hidden_instr_feeder;

  logic       clk, rst;
  logic       cmd_load, cmd_run, halt, load_valid, load_done;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] instr_out;
  logic       instr_valid, instr_ready, redirect_valid;
  logic [7:0] redirect_offset;
  logic [4:0] prog_len;
  logic [3:0] fetch_ptr;
  logic [7:0] instr_count;
  logic       wrapped;
  logic [1:0] state;

  hidden_instr_feeder #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .cmd_load(cmd_load), .cmd_run(cmd_run), .halt(halt),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_offset(redirect_offset), .prog_len(prog_len), .fetch_ptr(fetch_ptr),
    .instr_count(instr_count), .wrapped(wrapped), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cl, cr, h, lv;
    logic [7:0] ld;
    logic       ldn, ir, rv;
    logic [7:0] ro;
    int         eState, eValid, eInstr, eWrap, eCnt;
  } vec_t;

  localparam int IDLE = 0, LOAD = 1, RUN = 2, HALT = 3;

  int vectors = 0;
  int errors  = 0;

  int         mState, mLen, mPtr, mCnt, mWrap;
  logic [7:0] mMem [16];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic cl, cr, h, lv, input logic [7:0] ld,
                               input logic ldn, ir, rv, input logic [7:0] ro,
                               input int eState, eValid, eInstr, eWrap, eCnt);
    vec_t v;
    v.cl = cl; v.cr = cr; v.h = h; v.lv = lv; v.ld = ld;
    v.ldn = ldn; v.ir = ir; v.rv = rv; v.ro = ro;
    v.eState = eState; v.eValid = eValid; v.eInstr = eInstr; v.eWrap = eWrap; v.eCnt = eCnt;
    return v;
  endfunction

  // Stimulus-only record with optional instr_out / state expectations.
  function automatic vec_t st(input logic cl, cr, h, lv, input logic [7:0] ld,
                              input logic ldn, ir, rv, input logic [7:0] ro,
                              input int eInstr, input int eState);
    return mkv(cl, cr, h, lv, ld, ldn, ir, rv, ro, eState, -1, eInstr, -1, -1);
  endfunction

  task automatic modelReset();
    mState = IDLE; mLen = 0; mPtr = 0; mCnt = 0; mWrap = 0;
  endtask

  task automatic checkModel();
    chk("state", state, mState);
    chk("prog_len", prog_len, mLen);
    chk("fetch_ptr", fetch_ptr, mPtr);
    chk("instr_count", instr_count, mCnt);
    chk("wrapped", wrapped, mWrap);
    chk("load_ready", load_ready, (mState == LOAD && mLen < 16) ? 1 : 0);
    chk("instr_valid", instr_valid, (mState == RUN) ? 1 : 0);
    chk("instr_out", instr_out, (mState == RUN) ? int'(mMem[mPtr]) : 0);
  endtask

  task automatic modelStep(input vec_t v);
    int t;
    mWrap = 0;
    case (mState)
      IDLE: if (v.cl) begin mState = LOAD; mLen = 0; end
            else if (v.cr && mLen > 0) begin mState = RUN; mPtr = 0; mCnt = 0; end
      LOAD: begin
        if (v.lv && mLen < 16) begin mMem[mLen] = v.ld; mLen++; end
        if (v.ldn) mState = IDLE;
      end
      RUN: begin
        if (v.ir) begin
          mCnt = (mCnt + 1) % 256;
          if (v.rv) begin
            t = (mPtr + v.ro) % 16;
            mPtr = (t < mLen) ? t : 0;
          end else if (mPtr == mLen - 1) begin
            mPtr = 0; mWrap = 1;
          end else mPtr++;
        end
        if (v.h) mState = HALT;
      end
      default: if (v.cl) begin mState = LOAD; mLen = 0; end
               else if (v.cr) mState = RUN;
    endcase
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    cmd_load = v.cl; cmd_run = v.cr; halt = v.h; load_valid = v.lv; load_data = v.ld;
    load_done = v.ldn; instr_ready = v.ir; redirect_valid = v.rv; redirect_offset = v.ro;
    #1;
    checkModel();
    if (v.eState >= 0) chk("tbl_state", state, v.eState);
    if (v.eValid >= 0) chk("tbl_valid", instr_valid, v.eValid);
    if (v.eInstr >= 0) chk("tbl_instr", instr_out, v.eInstr);
    if (v.eWrap  >= 0) chk("tbl_wrapped", wrapped, v.eWrap);
    if (v.eCnt   >= 0) chk("tbl_count", instr_count, v.eCnt);
    modelStep(v);
  endtask

  task automatic idle(input int eInstr, input int eState);
    apply(st(0,0,0,0,8'h00,0,0,0,8'h00, eInstr, eState));
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = mkv(1,0,0,0,8'h00,0,0,0,8'h00, IDLE,0,8'h00,0,0);
    tbl[1]  = mkv(0,0,0,1,8'h11,0,0,0,8'h00, LOAD,0,8'h00,0,0);
    tbl[2]  = mkv(0,0,0,1,8'h22,0,0,0,8'h00, LOAD,0,8'h00,0,0);
    tbl[3]  = mkv(0,0,0,1,8'h33,0,0,0,8'h00, LOAD,0,8'h00,0,0);
    tbl[4]  = mkv(0,0,0,0,8'h00,1,0,0,8'h00, LOAD,0,8'h00,0,0);
    tbl[5]  = mkv(0,1,0,0,8'h00,0,0,0,8'h00, IDLE,0,8'h00,0,0);
    tbl[6]  = mkv(0,0,0,0,8'h00,0,1,0,8'h00, RUN,1,8'h11,0,0);
    tbl[7]  = mkv(0,0,0,0,8'h00,0,1,0,8'h00, RUN,1,8'h22,0,1);
    tbl[8]  = mkv(0,0,0,0,8'h00,0,1,0,8'h00, RUN,1,8'h33,0,2);
    tbl[9]  = mkv(0,0,0,0,8'h00,0,1,0,8'h00, RUN,1,8'h11,1,3);
    tbl[10] = mkv(0,0,0,0,8'h00,0,1,0,8'h00, RUN,1,8'h22,0,4);
    tbl[11] = mkv(0,0,0,0,8'h00,0,1,0,8'h00, RUN,1,8'h33,0,5);
    tbl[12] = mkv(0,0,1,0,8'h00,0,0,0,8'h00, RUN,1,8'h11,1,6);
    tbl[13] = mkv(0,0,0,0,8'h00,0,0,0,8'h00, HALT,0,8'h00,0,6);

    {cmd_load, cmd_run, halt, load_valid, load_done, instr_ready, redirect_valid} = '0;
    load_data = 8'h00; redirect_offset = 8'h00;
    rst = 1'b1;
    modelReset();
    #2;
    checkModel();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) apply(tbl[i]);

    // Overfill: 17 bytes offered, only 16 kept.
    apply(st(1,0,0,0,8'h00,0,0,0,8'h00, -1, HALT));
    for (int i = 0; i < 17; i++) apply(st(0,0,0,1,8'(8'h40 + i),0,0,0,8'h00, -1, LOAD));
    idle(-1, LOAD);
    chk("full_prog_len", prog_len, 16);
    chk("full_load_ready", load_ready, 0);
    apply(st(0,0,0,0,8'h00,1,0,0,8'h00, -1, LOAD));

    // Eight-entry program for redirect, stall and halt corners.
    apply(st(1,0,0,0,8'h00,0,0,0,8'h00, -1, IDLE));
    for (int i = 0; i < 8; i++) apply(st(0,0,0,1,8'(8'hA0 + i),0,0,0,8'h00, -1, LOAD));
    apply(st(0,0,0,0,8'h00,1,0,0,8'h00, -1, LOAD));
    apply(st(0,1,0,0,8'h00,0,0,0,8'h00, -1, IDLE));
    apply(st(0,0,0,0,8'h00,0,1,0,8'h00, 8'hA0, RUN));
    apply(st(0,0,0,0,8'h00,0,1,0,8'h00, 8'hA1, RUN));
    apply(st(0,0,0,0,8'h00,0,1,1,8'd3,  8'hA2, RUN));
    apply(st(0,0,0,0,8'h00,0,1,1,8'd15, 8'hA5, RUN));
    apply(st(0,0,0,0,8'h00,0,1,1,8'd7,  8'hA4, RUN));
    idle(8'hA0, RUN);
    chk("redir_no_wrap", wrapped, 0);

    apply(st(0,0,0,0,8'h00,0,1,0,8'h00, 8'hA0, RUN));
    apply(st(0,0,0,0,8'h00,0,0,0,8'h00, 8'hA1, RUN));
    apply(st(0,0,0,0,8'h00,0,0,0,8'h00, 8'hA1, RUN));
    apply(st(0,0,0,0,8'h00,0,1,0,8'h00, 8'hA1, RUN));
    idle(8'hA2, RUN);

    apply(st(0,0,0,0,8'h00,0,1,1,8'd15, 8'hA2, RUN));
    apply(st(0,0,1,0,8'h00,0,1,0,8'h00, 8'hA1, RUN));
    idle(8'h00, HALT);
    chk("halt_ptr", fetch_ptr, 2);
    chk("halt_valid", instr_valid, 0);
    apply(st(0,1,0,0,8'h00,0,0,0,8'h00, 8'h00, HALT));
    apply(st(0,0,0,0,8'h00,0,1,0,8'h00, 8'hA2, RUN));

    // Empty program: cmd_run must be ignored.
    apply(st(0,0,1,0,8'h00,0,0,0,8'h00, -1, RUN));
    apply(st(1,0,0,0,8'h00,0,0,0,8'h00, -1, HALT));
    apply(st(0,0,0,0,8'h00,1,0,0,8'h00, -1, LOAD));
    apply(st(0,1,0,0,8'h00,0,0,0,8'h00, -1, IDLE));
    idle(8'h00, IDLE);

    // Async reset between edges while running.
    apply(st(1,0,0,0,8'h00,0,0,0,8'h00, -1, IDLE));
    apply(st(0,0,0,1,8'h5A,0,0,0,8'h00, -1, LOAD));
    apply(st(0,0,0,1,8'h5B,1,0,0,8'h00, -1, LOAD));
    apply(st(0,1,0,0,8'h00,0,0,0,8'h00, -1, IDLE));
    apply(st(0,0,0,0,8'h00,0,1,0,8'h00, 8'h5A, RUN));
    apply(st(0,0,0,0,8'h00,0,1,0,8'h00, 8'h5B, RUN));
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkModel();
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v = mkv(($urandom_range(0,19) == 0), ($urandom_range(0,7) == 0),
              ($urandom_range(0,15) == 0), ($urandom_range(0,1) == 1),
              8'($urandom), ($urandom_range(0,11) == 0), ($urandom_range(0,2) != 0),
              ($urandom_range(0,3) == 0), 8'($urandom), -1, -1, -1, -1, -1);
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
